cdec_dp_gen: RTL and testbench

//  Parametrised next-generation CDEC data path: PC/I/T/R/MAR/WDR/RDR/FLG plus NGPR general registers on one XBUS.

---
 rtl/cdec_dp_gen.sv | 149 ++++++++++++++
 tb/tb_cdec_dp_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdec_dp_gen.sv
// cdec_dp_gen: CDEC data path with NGPR general registers and a req/ack memory FSM with timeout.
// Define CDEC_DBG_MON_EN to build the resad/resdt debug monitor mux; otherwise resdt is tied to zero.
module cdec_dp_gen #(
    parameter int DW          = 8,
    parameter int AW          = 8,
    parameter int NGPR        = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [3:0]    xsrc,
    input  logic [3:0]    xdst,
    input  logic          rwr,
    input  logic          fwr,
    input  logic          mem_rd,
    input  logic          mem_wr,
    output logic          busy,
    output logic          mem_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_adrs,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [DW-1:0] alu_x,
    output logic [DW-1:0] alu_t,
    output logic          alu_cy,
    input  logic [DW-1:0] alu_result,
    input  logic [2:0]    alu_flag,
    output logic [DW-1:0] I,
    output logic [2:0]    SZCy,
    input  logic [7:0]    resad,
    output logic [DW-1:0] resdt
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    typedef enum logic {IDLE, REQ} state_t;
    state_t state_q, state_d;
    logic we_q, we_d, err_q, err_d, rdr_ld;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] pc, ir, t, r, mar, wdr, rdr, xbus, flg_w;
    logic [2:0] flg;
    logic [DW-1:0] g [NGPR];
    always_comb begin
        flg_w = '0;
        flg_w[3:1] = flg;
    end
    always_comb begin
        xbus = xsrc == 4'd0 ? pc : xsrc == 4'd1 ? r : xsrc == 4'd2 ? rdr : xsrc == 4'd3 ? flg_w : '1;
        for (int k = 0; k < NGPR; k++)
            if (xsrc == 4'(4 + k)) xbus = g[k];
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
    // The counter runs only in REQ; an ack on the last allowed cycle still wins over the timeout.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        rdr_ld  = 1'b0;
        if (state_q == IDLE) begin
            if (mem_rd || mem_wr) begin
                state_d = REQ;
                we_d    = mem_wr;
                cnt_d   = '0;
            end
        end else if (mem_ack) begin
            state_d = IDLE;
            rdr_ld  = !we_q;
        end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end
    assign busy      = state_q == REQ;
    assign mem_req   = busy;
    assign mem_we    = busy && we_q;
    assign mem_err   = err_q;
    assign mem_adrs  = mar[AW-1:0];
    assign mem_wdata = wdr;
    assign alu_x     = xbus;
    assign alu_t     = t;
    assign alu_cy    = flg[0];
    assign I         = ir;
    assign SZCy      = flg;
    // MAR and WDR hold the in-flight address/data, so they are frozen while busy.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc  <= '0;
            ir  <= '0;
            t   <= '0;
            r   <= '0;
            mar <= '0;
            wdr <= '0;
            rdr <= '0;
            flg <= '0;
            for (int k = 0; k < NGPR; k++) g[k] <= '0;
        end else begin
            if (xdst == 4'd0) pc <= xbus;
            if (xdst == 4'd1) ir <= xbus;
            if (xdst == 4'd2) t <= xbus;
            if (xdst == 4'd3 && !busy) mar <= xbus;
            if (xdst == 4'd15 && !busy) wdr <= xbus;
            for (int k = 0; k < NGPR; k++)
                if (xdst == 4'(4 + k)) g[k] <= xbus;
            if (rwr) r <= alu_result;
            if (fwr) flg <= alu_flag;
            if (rdr_ld) rdr <= mem_rdata;
        end
    end
`ifdef CDEC_DBG_MON_EN
    always_comb begin
        resdt = '0;
        case (resad)
            8'h00: resdt = pc;
            8'h01: resdt = ir;
            8'h02: resdt = t;
            8'h03: resdt = r;
            8'h04: resdt = mar;
            8'h05: resdt = mem_rdata;
            8'h06: resdt = rdr;
            8'h07: resdt = wdr;
            8'h08: resdt = flg_w;
            8'h09: resdt = xbus;
            8'h0A: resdt[1:0] = {busy, err_q};
            default: ;
        endcase
        for (int k = 0; k < NGPR; k++)
            if (resad == 8'(16 + k)) resdt = g[k];
    end
`else
    logic unused;
    assign resdt  = '0;
    assign unused = ^{resad, mar};
`endif
endmodule

// File: tb/tb_cdec_dp_gen.sv
// tb_cdec_dp_gen: directed and randomized checks of cdec_dp_gen against a register-level reference model.
module tb_cdec_dp_gen;
    localparam int DW = 8, AW = 8, NGPR = 3, TO = 15;
    logic clock = 1'b0;
    logic reset, rwr, fwr, mem_rd, mem_wr, mem_ack;
    logic [3:0] xsrc, xdst;
    logic [DW-1:0] mem_rdata, alu_result;
    logic [2:0] alu_flag;
    logic [7:0] resad;
    logic busy, mem_err, mem_req, mem_we, alu_cy;
    logic [AW-1:0] mem_adrs;
    logic [DW-1:0] mem_wdata, alu_x, alu_t, I, resdt;
    logic [2:0] SZCy;
    int n_cmp = 0, n_err = 0, nreq;
    logic [7:0] m_pc, m_ir, m_t, m_r, m_mar, m_wdr, m_rdr;
    logic [2:0] m_flg;
    logic [7:0] m_g [NGPR];
    logic m_busy, m_we, m_err;
    int m_left;

    always #5 clock = ~clock;

    cdec_dp_gen #(.DW(DW), .AW(AW), .NGPR(NGPR), .MEM_TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .xsrc(xsrc), .xdst(xdst), .rwr(rwr), .fwr(fwr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .busy(busy), .mem_err(mem_err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_adrs(mem_adrs), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .alu_x(alu_x), .alu_t(alu_t), .alu_cy(alu_cy), .alu_result(alu_result),
        .alu_flag(alu_flag), .I(I), .SZCy(SZCy), .resad(resad), .resdt(resdt)
    );

    function automatic logic [7:0] m_xbus(input logic [3:0] s);
        if (s == 4'd0) return m_pc;
        if (s == 4'd1) return m_r;
        if (s == 4'd2) return m_rdr;
        if (s == 4'd3) return {4'b0, m_flg, 1'b0};
        if (int'(s) >= 4 && int'(s) < 4 + NGPR) return m_g[int'(s) - 4];
        return 8'hFF;
    endfunction

    function automatic logic [7:0] m_mon(input logic [7:0] a);
`ifdef CDEC_DBG_MON_EN
        if (int'(a) >= 16 && int'(a) < 16 + NGPR) return m_g[int'(a) - 16];
        case (a)
            8'h00: return m_pc;
            8'h01: return m_ir;
            8'h02: return m_t;
            8'h03: return m_r;
            8'h04: return m_mar;
            8'h05: return mem_rdata;
            8'h06: return m_rdr;
            8'h07: return m_wdr;
            8'h08: return {4'b0, m_flg, 1'b0};
            8'h09: return m_xbus(xsrc);
            8'h0A: return {6'b0, m_busy, m_err};
            default: return 8'h00;
        endcase
`else
        return a & 8'h00;
`endif
    endfunction

    task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic chk_all();
        chk("busy", 8'(busy), 8'(m_busy));
        chk("mem_req", 8'(mem_req), 8'(m_busy));
        chk("mem_we", 8'(mem_we), 8'(m_busy & m_we));
        chk("mem_err", 8'(mem_err), 8'(m_err));
        chk("mem_adrs", mem_adrs, m_mar);
        chk("mem_wdata", mem_wdata, m_wdr);
        chk("alu_x", alu_x, m_xbus(xsrc));
        chk("alu_t", alu_t, m_t);
        chk("alu_cy", 8'(alu_cy), 8'(m_flg[0]));
        chk("I", I, m_ir);
        chk("SZCy", 8'(SZCy), 8'(m_flg));
        chk("resdt", resdt, m_mon(resad));
    endtask

    // Model update from the inputs present before the edge, then settle past the edge.
    task automatic tick();
        logic [7:0] xb;
        logic ob, owe;
        xb  = m_xbus(xsrc);
        ob  = m_busy;
        owe = m_we;
        if (reset) begin
            {m_pc, m_ir, m_t, m_r, m_mar, m_wdr, m_rdr} = '0;
            m_flg = '0;
            for (int k = 0; k < NGPR; k++) m_g[k] = '0;
            {m_busy, m_we, m_err} = '0;
            m_left = 0;
        end else begin
            case (xdst)
                4'd0: m_pc = xb;
                4'd1: m_ir = xb;
                4'd2: m_t = xb;
                4'd3: if (!ob) m_mar = xb;
                4'd15: if (!ob) m_wdr = xb;
                default: if (int'(xdst) >= 4 && int'(xdst) < 4 + NGPR) m_g[int'(xdst) - 4] = xb;
            endcase
            if (rwr) m_r = alu_result;
            if (fwr) m_flg = alu_flag;
            if (!ob) begin
                if (mem_rd || mem_wr) begin
                    m_busy = 1'b1;
                    m_we   = mem_wr;
                    m_left = TO;
                end
            end else if (mem_ack) begin
                m_busy = 1'b0;
                if (!owe) m_rdr = mem_rdata;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_err  = 1'b1;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        {rwr, fwr, mem_rd, mem_wr, mem_ack} = '0;
        xdst = 4'd14;
    endtask

    initial begin
        reset = 1'b1;
        quiet();
        xsrc = 4'd0;
        mem_rdata = '0;
        alu_result = '0;
        alu_flag = '0;
        resad = '0;
        tick();
        tick();
        reset = 1'b0;
        xsrc = 4'd1;
        #1;
        chk("rst_xbus", alu_x, 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_err", 8'(mem_err), 8'h00);
        chk_all();
        for (int a = 0; a < 256; a++) begin
            resad = 8'(a);
            #1;
            chk("rst_resdt", resdt, 8'h00);
        end
        resad = 8'h00;

        xsrc = 4'hF; xdst = 4'd4; tick();
        xsrc = 4'd4; xdst = 4'd2; tick();
        quiet();
        chk("g0_to_t", alu_t, 8'hFF);
        chk_all();

        alu_result = 8'h12; rwr = 1'b1; tick();
        rwr = 1'b0; xsrc = 4'd1; xdst = 4'd3; tick();
        quiet();
        chk("mar_load", mem_adrs, 8'h12);
        mem_rd = 1'b1; tick();
        mem_rd = 1'b0;
        nreq = 0;
        for (int c = 0; c < 3; c++) begin
            if (mem_req) nreq++;
            chk_all();
            if (c == 2) begin
                mem_ack = 1'b1;
                mem_rdata = 8'hA5;
            end
            tick();
        end
        mem_ack = 1'b0;
        chk("rd_req_cycles", 8'(nreq), 8'd3);
        chk("rd_busy_low", 8'(busy), 8'h00);
        xsrc = 4'd2;
        #1;
        chk("rd_rdr", alu_x, 8'hA5);

        alu_result = 8'h3C; rwr = 1'b1; tick();
        rwr = 1'b0; xsrc = 4'd1; xdst = 4'd15; tick();
        quiet();
        mem_wr = 1'b1; mem_rd = 1'b1; tick();
        mem_wr = 1'b0; mem_rd = 1'b0;
        chk("wr_we", 8'(mem_we), 8'h01);
        chk("wr_wdata", mem_wdata, 8'h3C);
        xsrc = 4'd1; xdst = 4'd3; tick();
        quiet();
        chk("wr_mar_hold", mem_adrs, 8'h12);
        chk_all();
        mem_ack = 1'b1; mem_rdata = 8'h77; tick();
        mem_ack = 1'b0;
        xsrc = 4'd2;
        #1;
        chk("wr_rdr_kept", alu_x, 8'hA5);
        chk_all();

        mem_rd = 1'b1; tick();
        mem_rd = 1'b0;
        for (int c = 0; c < TO; c++) begin
            chk("to_busy", 8'(busy), 8'h01);
            tick();
        end
        chk("to_idle", 8'(busy), 8'h00);
        chk("to_err", 8'(mem_err), 8'h01);
        chk("to_rdr", alu_x, 8'hA5);
        mem_ack = 1'b1; mem_rdata = 8'h99; tick();
        mem_ack = 1'b0;
        chk("idle_ack_rdr", alu_x, 8'hA5);
        chk_all();
        reset = 1'b1; tick();
        reset = 1'b0;
        chk("rst_clr_err", 8'(mem_err), 8'h00);

        alu_result = 8'h5A; rwr = 1'b1; tick();
        rwr = 1'b0; xsrc = 4'd1; xdst = 4'd6; tick();
        quiet();
        resad = 8'h12;
        #1;
`ifdef CDEC_DBG_MON_EN
        chk("mon_g2", resdt, 8'h5A);
`else
        chk("mon_g2", resdt, 8'h00);
`endif
        resad = 8'h0B;
        #1;
        chk("mon_gap", resdt, 8'h00);

        for (int n = 0; n < 600; n++) begin
            reset      = $urandom_range(0, 63) == 0;
            xsrc       = 4'($urandom_range(0, 15));
            xdst       = 4'($urandom_range(0, 15));
            rwr        = $urandom_range(0, 2) == 0;
            fwr        = $urandom_range(0, 2) == 0;
            mem_rd     = $urandom_range(0, 3) == 0;
            mem_wr     = $urandom_range(0, 3) == 0;
            mem_ack    = $urandom_range(0, 3) == 0;
            mem_rdata  = 8'($urandom);
            alu_result = 8'($urandom);
            alu_flag   = 3'($urandom);
            resad      = 8'($urandom_range(0, 31));
            tick();
            chk_all();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
